// File: rtl/cla_mw_seq.sv
// cla_mw_seq: operand sequencer and result stage for an external
// combinational carry-lookahead adder.
//
// Operand beats arrive over a valid/ready stream and are registered in S1.
// S1 drives the adder directly. The adder's sum and carry-out are captured
// into S2, and S2 drives the result stream. The carry-out of each word is
// chained into the carry-in of the next word, so wide add/subtract
// operations run as little-endian word sequences at one beat per cycle.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | no operation open; the next beat starts a new operation
// ST_CHAIN | multi-word operation open; the next beat continues it
module cla_mw_seq #(
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_a,
    input  logic [DATA_WIDTH-1:0] in_b,
    input  logic                  in_sub,
    input  logic                  in_first,
    input  logic                  in_last,
    output logic [DATA_WIDTH-1:0] add_a,
    output logic [DATA_WIDTH-1:0] add_b,
    output logic                  add_cin,
    input  logic [DATA_WIDTH-1:0] add_sum,
    input  logic                  add_cout,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_sum,
    output logic                  out_cout,
    output logic                  out_ovf,
    output logic                  out_last,
    output logic                  err
);

    localparam int MSB = DATA_WIDTH - 1;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CHAIN = 1'b1
    } state_t;

    state_t                r_state;
    logic                  r_op_sub;
    logic                  r_err;

    logic                  r_s1_valid;
    logic [DATA_WIDTH-1:0] r_s1_a;
    logic [DATA_WIDTH-1:0] r_s1_b;
    logic                  r_s1_first;
    logic                  r_s1_last;
    logic                  r_s1_sub;

    logic                  r_carry;

    logic                  r_s2_valid;
    logic [DATA_WIDTH-1:0] r_s2_sum;
    logic                  r_s2_cout;
    logic                  r_s2_ovf;
    logic                  r_s2_last;

    logic                  w_s1_adv;
    logic                  w_in_fire;
    logic                  w_s1_xfer;
    logic                  w_beat_first;
    logic                  w_beat_sub;
    logic                  w_proto_err;
    logic                  w_ovf;

    // S1 may move on when S2 is empty or S2 is being drained this cycle.
    // in_ready depends only on registers and out_ready, never on in_valid.
    assign w_s1_adv  = !r_s2_valid || out_ready;
    assign in_ready  = !r_s1_valid || w_s1_adv;
    assign w_in_fire = in_valid && in_ready;
    assign w_s1_xfer = r_s1_valid && w_s1_adv;

    // A beat arriving with no open operation always starts one, even if it
    // is not flagged first; that case and a first beat inside an open
    // operation are both protocol errors.
    assign w_beat_first = in_first || (r_state == ST_IDLE);
    assign w_beat_sub   = w_beat_first ? in_sub : r_op_sub;
    assign w_proto_err  = ((r_state == ST_IDLE)  && !in_first) ||
                          ((r_state == ST_CHAIN) &&  in_first);

    // Signed overflow only makes sense on the most-significant word.
    assign w_ovf = r_s1_last &&
                   (r_s1_a[MSB] == r_s1_b[MSB]) &&
                   (add_sum[MSB] != r_s1_a[MSB]);

    // Operation tracking: open/close state, held op type, sticky error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_op_sub <= 1'b0;
            r_err    <= 1'b0;
        end else if (w_in_fire) begin
            r_op_sub <= w_beat_sub;
            if (w_proto_err) begin
                r_err <= 1'b1;
            end
            r_state <= in_last ? ST_IDLE : ST_CHAIN;
        end
    end

    // S1: register the accepted beat; hold it (and the adder inputs) on stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
            r_s1_first <= 1'b0;
            r_s1_last  <= 1'b0;
            r_s1_sub   <= 1'b0;
        end else if (w_in_fire) begin
            r_s1_valid <= 1'b1;
            r_s1_a     <= in_a;
            r_s1_b     <= w_beat_sub ? ~in_b : in_b;
            r_s1_first <= w_beat_first;
            r_s1_last  <= in_last;
            r_s1_sub   <= w_beat_sub;
        end else if (w_s1_adv) begin
            r_s1_valid <= 1'b0;
        end
    end

    // S2 and carry chain: capture the adder result as S1 moves on. The carry
    // is updated only on that transfer, so it always belongs to the word now
    // in S2 and the next word's carry-in survives any stall pattern.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_carry    <= 1'b0;
            r_s2_valid <= 1'b0;
            r_s2_sum   <= '0;
            r_s2_cout  <= 1'b0;
            r_s2_ovf   <= 1'b0;
            r_s2_last  <= 1'b0;
        end else if (w_s1_xfer) begin
            r_carry    <= add_cout;
            r_s2_valid <= 1'b1;
            r_s2_sum   <= add_sum;
            r_s2_cout  <= add_cout;
            r_s2_ovf   <= w_ovf;
            r_s2_last  <= r_s1_last;
        end else if (out_ready) begin
            r_s2_valid <= 1'b0;
        end
    end

    assign add_a   = r_s1_a;
    assign add_b   = r_s1_b;
    assign add_cin = r_s1_first ? r_s1_sub : r_carry;

    assign out_valid = r_s2_valid;
    assign out_sum   = r_s2_sum;
    assign out_cout  = r_s2_cout;
    assign out_ovf   = r_s2_ovf;
    assign out_last  = r_s2_last;
    assign err       = r_err;

endmodule

// File: tb/tb_cla_mw_seq.sv
// Testbench for cla_mw_seq with a behavioural adder attached.
module tb_cla_mw_seq;

    localparam int DW = 64;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_a;
    logic [DW-1:0] in_b;
    logic          in_sub;
    logic          in_first;
    logic          in_last;
    logic [DW-1:0] add_a;
    logic [DW-1:0] add_b;
    logic          add_cin;
    logic [DW-1:0] add_sum;
    logic          add_cout;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_sum;
    logic          out_cout;
    logic          out_ovf;
    logic          out_last;
    logic          err;

    logic [DW:0]   w_add;

    cla_mw_seq #(.DATA_WIDTH(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_sub(in_sub),
        .in_first(in_first), .in_last(in_last),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_sum(add_sum), .add_cout(add_cout),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf),
        .out_last(out_last), .err(err)
    );

    // Combinational adder standing in for the carry-lookahead block.
    assign w_add    = {1'b0, add_a} + {1'b0, add_b} + {{DW{1'b0}}, add_cin};
    assign add_sum  = w_add[DW-1:0];
    assign add_cout = w_add[DW];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic          sub;
        logic          first;
        logic          last;
        int            gap;
    } beat_t;

    typedef struct {
        logic [DW-1:0] sum;
        logic          cout;
        logic          ovf;
        logic          last;
    } res_t;

    typedef struct {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic          sub;
        logic [DW-1:0] sum;
        logic          cout;
        logic          ovf;
    } vec_t;

    beat_t sendq[$];
    res_t  expq[$];
    int    total = 0;
    int    bad   = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add_beat(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic sub,
                            input logic first, input logic last, input int gap);
        beat_t h;
        h.a = a; h.b = b; h.sub = sub; h.first = first; h.last = last; h.gap = gap;
        sendq.push_back(h);
    endtask

    task automatic add_exp(input logic [DW-1:0] sum, input logic cout, input logic ovf, input logic last);
        res_t r;
        r.sum = sum; r.cout = cout; r.ovf = ovf; r.last = last;
        expq.push_back(r);
    endtask

    // Reference model: an n-word operation is one wide integer add of
    // A + (sub ? ~B : B) + sub. Each word's carry-out is the carry leaving the
    // low k+1 words; overflow is judged on the top bit of the whole operand.
    task automatic push_op(input int n, input logic [255:0] A, input logic [255:0] B,
                           input logic sub, input int gap);
        logic [256:0] msk, ae, be, part;
        int           lo;
        res_t         r;
        for (int k = 0; k < n; k++) begin
            lo   = DW * (k + 1);
            msk  = (257'd1 << lo) - 257'd1;
            ae   = {1'b0, A} & msk;
            be   = (sub ? ~{1'b0, B} : {1'b0, B}) & msk;
            part = ae + be + {256'd0, sub};
            r.sum  = DW'(part >> (DW * k));
            r.cout = part[lo];
            r.last = (k == n - 1);
            r.ovf  = r.last && (ae[lo-1] == be[lo-1]) && (part[lo-1] != ae[lo-1]);
            expq.push_back(r);
            add_beat(DW'(A >> (DW * k)), DW'(B >> (DW * k)),
                     (k == 0) ? sub : 1'($urandom_range(0, 1)),
                     (k == 0), (k == n - 1), (k == 0) ? 0 : gap);
        end
    endtask

    // Drive queued beats and check results, one cycle per iteration.
    // Inputs change on the falling edge; everything is sampled 1 ns later.
    task automatic run(input bit rnd, input int budget, output int cycles);
        beat_t h;
        res_t  e;
        int    cyc;
        cyc = 0;
        while ((sendq.size() != 0 || expq.size() != 0) && cyc < budget) begin
            @(negedge clk);
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            in_valid  = 1'b0;
            if (sendq.size() != 0) begin
                h = sendq[0];
                if (h.gap > 0) begin
                    h.gap--;
                    sendq[0] = h;
                end else begin
                    in_valid = 1'b1;
                    in_a = h.a; in_b = h.b; in_sub = h.sub;
                    in_first = h.first; in_last = h.last;
                end
            end
            #1;
            if (out_valid && out_ready) begin
                if (expq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL extra_output: got sum %h with nothing expected", out_sum);
                end else begin
                    e = expq.pop_front();
                    chk("out_sum",  out_sum,  e.sum);
                    chk("out_cout", out_cout, e.cout);
                    chk("out_ovf",  out_ovf,  e.ovf);
                    chk("out_last", out_last, e.last);
                end
            end
            if (in_valid && in_ready) begin
                h = sendq.pop_front();
            end
            cyc++;
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        if (sendq.size() != 0 || expq.size() != 0) begin
            total++;
            bad++;
            $display("FAIL timeout: pending beats %0d results %0d required 0 0", sendq.size(), expq.size());
            sendq.delete();
            expq.delete();
        end
        cycles = cyc;
    endtask

    initial begin
        vec_t          tbl[6];
        int            cyc;
        logic [255:0]  ra, rb;
        int            n;

        tbl[0] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'd0, 1'b1, 1'b0};
        tbl[1] = '{64'd5, 64'd7, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0};
        tbl[2] = '{64'h8000_0000_0000_0000, 64'd1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1};
        tbl[3] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
        tbl[4] = '{64'd0, 64'd0, 1'b1, 64'd0, 1'b1, 1'b0};
        tbl[5] = '{64'h1234, 64'h4321, 1'b0, 64'h5555, 1'b0, 1'b0};

        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_sub = 1'b0;
        in_first = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        #1;
        chk("rst_in_ready",  in_ready,  1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_sum",   out_sum,   64'd0);
        chk("rst_out_cout",  out_cout,  1'b0);
        chk("rst_out_ovf",   out_ovf,   1'b0);
        chk("rst_out_last",  out_last,  1'b0);
        chk("rst_err",       err,       1'b0);
        chk("rst_add_a",     add_a,     64'd0);
        chk("rst_add_b",     add_b,     64'd0);
        chk("rst_add_cin",   add_cin,   1'b0);
        #11 rst_n = 1'b1;

        // Single-word table, streamed back to back at full rate.
        for (int i = 0; i < 6; i++) begin
            add_beat(tbl[i].a, tbl[i].b, tbl[i].sub, 1'b1, 1'b1, 0);
            add_exp(tbl[i].sum, tbl[i].cout, tbl[i].ovf, 1'b1);
        end
        run(1'b0, 50, cyc);
        chk("throughput_cycles", 64'(cyc), 64'd8);

        // 128-bit add, carry from low word into high word.
        add_beat(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b1, 1'b0, 0);
        add_beat(64'd0, 64'd0, 1'b0, 1'b0, 1'b1, 0);
        add_exp(64'd0, 1'b1, 1'b0, 1'b0);
        add_exp(64'd1, 1'b0, 1'b0, 1'b1);
        run(1'b0, 20, cyc);

        // Full stall between the words of a 2-word add: carry and outputs hold.
        @(negedge clk);
        out_ready = 1'b0;
        in_valid = 1'b1; in_a = 64'hFFFF_FFFF_FFFF_FFFF; in_b = 64'd1; in_sub = 1'b0;
        in_first = 1'b1; in_last = 1'b0;
        #1 chk("stall_ready0", in_ready, 1'b1);
        @(negedge clk);
        in_a = 64'd0; in_b = 64'd0; in_first = 1'b0; in_last = 1'b1;
        #1 chk("stall_ready1", in_ready, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("stall_ready_full", in_ready,  1'b0);
        chk("stall_out_valid",  out_valid, 1'b1);
        chk("stall_out_cout",   out_cout,  1'b1);
        chk("stall_add_cin",    add_cin,   1'b1);
        repeat (3) @(negedge clk);
        #1;
        chk("stall_hold_sum",   out_sum,   64'd0);
        chk("stall_hold_last",  out_last,  1'b0);
        chk("stall_hold_cin",   add_cin,   1'b1);
        chk("stall_hold_ready", in_ready,  1'b0);
        add_exp(64'd0, 1'b1, 1'b0, 1'b0);
        add_exp(64'd1, 1'b0, 1'b0, 1'b1);
        run(1'b0, 20, cyc);

        // Random back-pressure: 8 adds of i+i, a stalled 2-word op, random ops.
        for (int i = 0; i < 8; i++) begin
            push_op(1, 256'(i), 256'(i), 1'b0, 0);
        end
        ra = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        rb = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        push_op(2, ra, rb, 1'($urandom_range(0, 1)), 4);
        for (int i = 0; i < 24; i++) begin
            n  = $urandom_range(1, 3);
            ra = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            rb = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            if (i % 4 == 0) rb = ~ra;
            push_op(n, ra, rb, 1'($urandom_range(0, 1)), $urandom_range(0, 2));
        end
        run(1'b1, 3000, cyc);
        chk("err_clean_protocol", err, 1'b0);

        // Protocol errors: non-first beat with no op open, first beat in an open op.
        add_beat(64'd3, 64'd4, 1'b0, 1'b0, 1'b1, 0);
        add_exp(64'd7, 1'b0, 1'b0, 1'b1);
        run(1'b0, 20, cyc);
        chk("err_set", err, 1'b1);
        add_beat(64'd9, 64'd2, 1'b1, 1'b0, 1'b1, 0);
        add_exp(64'd7, 1'b1, 1'b0, 1'b1);
        add_beat(64'd1, 64'd1, 1'b0, 1'b1, 1'b0, 0);
        add_exp(64'd2, 1'b0, 1'b0, 1'b0);
        add_beat(64'd10, 64'd3, 1'b1, 1'b1, 1'b1, 0);
        add_exp(64'd7, 1'b1, 1'b0, 1'b1);
        add_beat(64'd20, 64'd22, 1'b0, 1'b1, 1'b1, 0);
        add_exp(64'd42, 1'b0, 1'b0, 1'b1);
        run(1'b0, 30, cyc);
        chk("err_sticky", err, 1'b1);

        // Reset in the middle of a 2-word op.
        @(negedge clk);
        out_ready = 1'b0;
        in_valid = 1'b1; in_a = 64'hFFFF_FFFF_FFFF_FFFF; in_b = 64'd1; in_sub = 1'b0;
        in_first = 1'b1; in_last = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        #1 chk("mid_pre_valid", out_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("mid_out_valid", out_valid, 1'b0);
        chk("mid_in_ready",  in_ready,  1'b1);
        chk("mid_add_cin",   add_cin,   1'b0);
        chk("mid_add_a",     add_a,     64'd0);
        chk("mid_err",       err,       1'b0);
        chk("mid_out_sum",   out_sum,   64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        add_beat(64'd1, 64'd1, 1'b0, 1'b1, 1'b1, 0);
        add_exp(64'd2, 1'b0, 1'b0, 1'b1);
        run(1'b0, 20, cyc);
        chk("post_rst_err", err, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
